serial_frame_rx: RTL

- Receiver end of the single-bit framed serial link driven by the netlist's serializer blocks.
- Samples one serial line on bit strobes and recognises start / data / optional parity / stop framing.
- Reassembles data LSB-first into a WIDTH-bit parallel word and pulses a valid flag per good frame.
- Flags framing and parity errors; sits between a 1-bit serial net and an 8-bit parallel bus consumer.

---
 rtl/serial_frame_rx.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start / LSB-first data / optional parity / stop.
// Reassembles a WIDTH-bit word and flags framing and parity errors.
module serial_frame_rx #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned PARITY = 0,
   parameter int unsigned CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in,
   output logic [WIDTH-1:0] out,
   output logic             out_vld,
   output logic             err_frame,
   output logic             err_par,
   output logic             busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DATA  = 3'd1;
   localparam logic [2:0] PAR   = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic             PAR_EN   = (PARITY != 0);
   localparam logic             PAR_ODD  = (PARITY == 2);

   logic [2:0]       state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             acc, acc_nxt;
   logic             par_bad, par_bad_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             vld_nxt, ferr_nxt, perr_nxt;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         acc       <= 1'b0;
         par_bad   <= 1'b0;
         out       <= '0;
         out_vld   <= 1'b0;
         err_frame <= 1'b0;
         err_par   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         cnt       <= cnt_nxt;
         acc       <= acc_nxt;
         par_bad   <= par_bad_nxt;
         out       <= out_nxt;
         out_vld   <= vld_nxt;
         err_frame <= ferr_nxt;
         err_par   <= perr_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

   // Next-state and output decode; nothing advances without a strobe
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      cnt_nxt     = cnt;
      acc_nxt     = acc;
      par_bad_nxt = par_bad;
      out_nxt     = out;
      vld_nxt     = 1'b0;
      ferr_nxt    = 1'b0;
      perr_nxt    = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (!in) begin
                  state_nxt   = DATA;
                  cnt_nxt     = '0;
                  acc_nxt     = 1'b0;
                  par_bad_nxt = 1'b0;
               end
            end
            DATA: begin
               shreg_nxt = {in, shreg[WIDTH-1:1]};
               acc_nxt   = acc ^ in;
               cnt_nxt   = cnt + 1'b1;
               if (cnt == LAST_BIT) state_nxt = PAR_EN ? PAR : STOP;
            end
            PAR: begin
               par_bad_nxt = par_bad | ((acc ^ in) != PAR_ODD);
               state_nxt   = STOP;
            end
            STOP: begin
               if (in) begin
                  state_nxt = IDLE;
                  if (par_bad) begin
                     perr_nxt = 1'b1;
                  end else begin
                     out_nxt = shreg;
                     vld_nxt = 1'b1;
                  end
               end else begin
                  // Line stuck low: hold off new starts until it returns high
                  state_nxt = BREAK;
                  ferr_nxt  = 1'b1;
                  perr_nxt  = par_bad;
               end
            end
            BREAK: begin
               if (in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
